// File: rtl/bit_timer_if.sv
// Receive bit-timer bus: start/abort/period from the edge detector side,
// strobes and status back toward the shift register and control logic.
interface bit_timer_if #(
   parameter int CNT_BITS = 8
);
   logic                start;
   logic                abort;
   logic [CNT_BITS-1:0] bit_period;
   logic                shift_strobe;
   logic                parity_strobe;
   logic                stop_strobe;
   logic                packet_done;
   logic                busy;
   logic [3:0]          bit_idx;

   modport master (
      output start, abort, bit_period,
      input  shift_strobe, parity_strobe, stop_strobe, packet_done, busy, bit_idx
   );

   modport slave (
      input  start, abort, bit_period,
      output shift_strobe, parity_strobe, stop_strobe, packet_done, busy, bit_idx
   );
endinterface

// File: rtl/bit_timer_ctrl.sv
// Receive bit-timing sequencer. After an accepted start it waits half a bit,
// then issues one mid-bit shift strobe per data bit, an optional parity strobe,
// a stop strobe and finally a one-cycle packet_done.
// Optional feature macro: PARITY_SLOT_EN adds one parity slot after the data bits.
module bit_timer_ctrl #(
   parameter int CNT_BITS  = 8,
   parameter int DATA_BITS = 8
) (
   input logic       clk,
   input logic       n_rst,
   bit_timer_if.slave bus
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_HALF   = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
`ifdef PARITY_SLOT_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   localparam logic [3:0] LAST_IDX = 4'(DATA_BITS - 1);

`ifdef PARITY_SLOT_EN
   localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
   localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif

   logic [2:0]          state_q, state_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic [CNT_BITS-1:0] p_q, p_d;
   logic [3:0]          bit_idx_q, bit_idx_d;

   logic [CNT_BITS-1:0] p_new;
   logic                half_end;
   logic                bit_end;
   logic                shift_s;
   logic                stop_s;
   logic                done_s;
`ifdef PARITY_SLOT_EN
   logic                parity_s;
`endif

   // Periods below 2 would give a zero-length half bit, so clamp to 2.
   assign p_new    = (bus.bit_period < CNT_BITS'(2)) ? CNT_BITS'(2) : bus.bit_period;
   assign half_end = (cnt_q == ((p_q >> 1) - CNT_BITS'(1)));
   assign bit_end  = (cnt_q == (p_q - CNT_BITS'(1)));

   // Next-state, counter rollover and strobe decode; abort overrides everything.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      p_d       = p_q;
      bit_idx_d = bit_idx_q;
      shift_s   = 1'b0;
      stop_s    = 1'b0;
      done_s    = 1'b0;
`ifdef PARITY_SLOT_EN
      parity_s  = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.abort) begin
               p_d       = p_new;
               bit_idx_d = 4'd0;
               cnt_d     = '0;
               state_d   = S_HALF;
            end
         end
         S_HALF: begin
            if (half_end) begin
               cnt_d   = '0;
               state_d = S_DATA;
            end else begin
               cnt_d = cnt_q + CNT_BITS'(1);
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_d     = '0;
               shift_s   = 1'b1;
               bit_idx_d = bit_idx_q + 4'd1;
               if (bit_idx_q == LAST_IDX) begin
                  state_d = S_AFTER_DATA;
               end
            end else begin
               cnt_d = cnt_q + CNT_BITS'(1);
            end
         end
`ifdef PARITY_SLOT_EN
         S_PARITY: begin
            if (bit_end) begin
               cnt_d    = '0;
               parity_s = 1'b1;
               state_d  = S_STOP;
            end else begin
               cnt_d = cnt_q + CNT_BITS'(1);
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               cnt_d   = '0;
               stop_s  = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_BITS'(1);
            end
         end
         S_DONE: begin
            done_s  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      if (bus.abort && (state_q != S_IDLE)) begin
         state_d   = S_IDLE;
         cnt_d     = '0;
         p_d       = p_q;
         bit_idx_d = bit_idx_q;
         shift_s   = 1'b0;
         stop_s    = 1'b0;
         done_s    = 1'b0;
`ifdef PARITY_SLOT_EN
         parity_s  = 1'b0;
`endif
      end
   end

   // State, counters and latched period; async reset returns everything to idle.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         p_q       <= '0;
         bit_idx_q <= 4'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         p_q       <= p_d;
         bit_idx_q <= bit_idx_d;
      end
   end

   assign bus.shift_strobe  = shift_s;
   assign bus.stop_strobe   = stop_s;
   assign bus.packet_done   = done_s;
   assign bus.busy          = (state_q != S_IDLE);
   assign bus.bit_idx       = bit_idx_q;
`ifdef PARITY_SLOT_EN
   assign bus.parity_strobe = parity_s;
`else
   assign bus.parity_strobe = 1'b0;
`endif

endmodule

// File: tb/tb_bit_timer_ctrl.sv
// Directed bench for bit_timer_ctrl: per-cycle comparison of all outputs
// against the packet timing formulas (H = P/2, strobe k at H + k*P, ...).
module tb_bit_timer_ctrl;

   localparam int DATA_BITS = 8;
   localparam int NO_ABORT  = 1000000;
`ifdef PARITY_SLOT_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic clk;
   logic n_rst;
   int   vectors;
   int   miscompares;
   int   last_idx;

   bit_timer_if #(.CNT_BITS(8)) bus ();

   bit_timer_ctrl #(.CNT_BITS(8), .DATA_BITS(DATA_BITS)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {busy, shift, parity, stop, done, bit_idx[3:0]} in cycle rel of a packet.
   function automatic logic [8:0] expect_vec(int rel, int p, int a, int prev);
      int h, stop_c, idx;
      logic busy, sh, par, st, dn;
      h      = p / 2;
      stop_c = h + (DATA_BITS + PAR + 1) * p;
      busy   = (rel >= 1) && (rel <= stop_c + 1) && (rel <= a);
      sh     = 1'b0;
      idx    = 0;
      for (int k = 1; k <= DATA_BITS; k++) begin
         if (rel == h + k * p && rel < a) sh = 1'b1;
         if (h + k * p < rel && h + k * p < a) idx++;
      end
      if (rel == 0) idx = prev;
      par = (PAR == 1) && (rel == h + (DATA_BITS + 1) * p) && (rel < a);
      st  = (rel == stop_c) && (rel < a);
      dn  = (rel == stop_c + 1) && (rel < a);
      return {busy, sh, par, st, dn, 4'(idx)};
   endfunction

   function automatic logic [8:0] observed();
      return {bus.busy, bus.shift_strobe, bus.parity_strobe, bus.stop_strobe,
              bus.packet_done, bus.bit_idx};
   endfunction

   // Entry/exit point: 1 time unit after a rising edge. ncheck=0 means full packet + idle cycle.
   task automatic run_packet(input string name, input int p_in, input int p_eff,
                             input int abort_at, input int extra_at, input int ncheck);
      int n;
      logic [8:0] exp_v, got_v;
      n = (ncheck == 0) ? (p_eff / 2 + (DATA_BITS + PAR + 1) * p_eff + 2) : ncheck;
      bus.bit_period = 8'(p_in);
      for (int rel = 0; rel < n; rel++) begin
         bus.start = (rel == 0) || (rel == extra_at);
         bus.abort = (rel == abort_at);
         if (rel == extra_at) bus.bit_period = 8'd4;
         @(negedge clk);
         exp_v = expect_vec(rel, p_eff, abort_at, last_idx);
         got_v = observed();
         vectors++;
         if (got_v !== exp_v) begin
            miscompares++;
            $display("[TB] FAIL %s rel=%0d got=%b expected=%b (busy,shift,par,stop,done,idx)",
                     name, rel, got_v, exp_v);
         end
         @(posedge clk);
         #1;
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;
      last_idx  = int'(expect_vec(n, p_eff, abort_at, last_idx) & 9'h00F);
   endtask

   task automatic check_idle(input string name, input int cycles, input int idx);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         vectors++;
         if (observed() !== {5'b0, 4'(idx)}) begin
            miscompares++;
            $display("[TB] FAIL %s cycle=%0d got=%b expected=%b", name, i, observed(),
                     {5'b0, 4'(idx)});
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.bit_period = 8'd10;
      last_idx = 0;
      repeat (2) @(posedge clk);
      check_idle("reset_hold", 2, 0);
      @(negedge clk);
      n_rst = 1'b1;
      @(posedge clk);
      #1;
      check_idle("reset_release", 3, 0);
   endtask

   task automatic test_idle_abort();
      bus.abort = 1'b1;
      check_idle("abort_in_idle", 3, 0);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      check_idle("start_with_abort", 5, 0);
   endtask

   task automatic test_nominal();
      run_packet("nominal_p10", 10, 10, NO_ABORT, -1, 0);
      vectors++;
      if (bus.bit_idx !== 4'd8) begin
         miscompares++;
         $display("[TB] FAIL nominal_final_idx got=%0d expected=8", bus.bit_idx);
      end
   endtask

   task automatic test_back_to_back();
      run_packet("b2b_p10", 10, 10, NO_ABORT, -1, 0);
      run_packet("b2b_p1", 1, 2, NO_ABORT, -1, 0);
      run_packet("b2b_p0", 0, 2, NO_ABORT, -1, 0);
   endtask

   task automatic test_odd_period();
      run_packet("odd_p7", 7, 7, NO_ABORT, -1, 0);
   endtask

   task automatic test_start_ignored();
      run_packet("busy_start_p10", 10, 10, NO_ABORT, 50, 0);
   endtask

   task automatic test_abort();
      run_packet("abort_at40", 10, 10, 40, -1, 60);
      vectors++;
      if (bus.bit_idx !== 4'd3 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL abort_hold got idx=%0d busy=%b expected idx=3 busy=0",
                  bus.bit_idx, bus.busy);
      end
      run_packet("abort_on_strobe45", 10, 10, 45, -1, 60);
      run_packet("abort_on_done", 4, 4, 2 + (DATA_BITS + PAR + 1) * 4 + 1, -1, 50);
   endtask

   task automatic test_max_period();
      run_packet("max_p255", 255, 255, NO_ABORT, -1, 0);
   endtask

   task automatic test_async_reset();
      run_packet("pre_reset_p10", 10, 10, NO_ABORT, -1, 50);
      n_rst = 1'b0;
      #1;
      vectors++;
      if (observed() !== 9'b0) begin
         miscompares++;
         $display("[TB] FAIL async_reset_immediate got=%b expected=%b", observed(), 9'b0);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_rst = 1'b1;
      @(posedge clk);
      #1;
      last_idx = 0;
      check_idle("after_reset_quiet", 120, 0);
      run_packet("after_reset_p10", 10, 10, NO_ABORT, -1, 0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_idle_abort();
      test_nominal();
      test_back_to_back();
      test_odd_period();
      test_start_ignored();
      test_abort();
      test_max_period();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
